// File: rtl/noc_pe_interface.sv
// PE-side network interface: ejection FIFO with destination check,
// and a multicast injection FSM toward the switch PE port.
module noc_pe_interface #(
  parameter int X_SIZE      = 2,
  parameter int Y_SIZE      = 2,
  parameter int DATA_WIDTH  = 8,
  parameter int TOTAL_WIDTH = 2*X_SIZE+2*Y_SIZE+DATA_WIDTH,
  parameter logic [X_SIZE-1:0] MY_X = '0,
  parameter logic [Y_SIZE-1:0] MY_Y = '0,
  parameter int FIFO_DEPTH  = 4,
  parameter int NUM_DEST    = 4,
  parameter logic [NUM_DEST*(X_SIZE+Y_SIZE)-1:0] DEST_LIST = 16'hDC98
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     sw_valid_in,
  input  logic [TOTAL_WIDTH-1:0]   sw_data_in,
  output logic                     sw_ready_out,
  output logic                     sw_valid_out,
  output logic [TOTAL_WIDTH-1:0]   sw_data_out,
  input  logic                     sw_ready_in,
  output logic                     nrn_valid_out,
  output logic [DATA_WIDTH-1:0]    nrn_data_out,
  output logic [X_SIZE+Y_SIZE-1:0] nrn_src_out,
  input  logic                     nrn_ready_in,
  input  logic                     nrn_valid_in,
  input  logic [DATA_WIDTH-1:0]    nrn_data_in,
  output logic                     nrn_ready_out,
  output logic [7:0]               misroute_cnt
);

  localparam int CW = X_SIZE + Y_SIZE;
  localparam int EW = DATA_WIDTH + CW;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = 4;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [IW-1:0] LAST_C = IW'(NUM_DEST - 1);

  typedef enum logic {IDLE, SEND} state_e;

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [7:0]    mis_q, mis_d;
  logic          full, empty, accept, match, push, pop;

  state_e              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]       dest;

  assign full   = (cnt_q == DEPTH_C);
  assign empty  = (cnt_q == '0);
  assign match  = (sw_data_in[CW-1:0] == {MY_X, MY_Y});
  assign accept = sw_valid_in & sw_ready_out;
  assign push   = accept & match;
  assign pop    = ~empty & nrn_ready_in;

  assign sw_ready_out  = rstn & ~full;
  assign nrn_valid_out = ~empty;
  assign {nrn_data_out, nrn_src_out} = mem_q[rd_q];
  assign misroute_cnt  = mis_q;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    mis_d = mis_q;
    if (push) wr_d = wr_q + 1'b1;
    if (pop)  rd_d = rd_q + 1'b1;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (accept && !match && mis_q != 8'hFF)
      mis_d = mis_q + 8'd1;
  end

  // Payload storage needs no reset; validity lives in cnt_q.
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_q] <= sw_data_in[TOTAL_WIDTH-1:2*CW+0] == '0 ?
        {sw_data_in[TOTAL_WIDTH-1:2*CW], sw_data_in[2*CW-1:CW]} :
        {sw_data_in[TOTAL_WIDTH-1:2*CW], sw_data_in[2*CW-1:CW]};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      mis_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      mis_q <= mis_d;
    end
  end

  always_comb begin
    dest = DEST_LIST[CW-1:0];
    for (int i = 0; i < NUM_DEST; i++)
      if (idx_q == IW'(i)) dest = DEST_LIST[i*CW +: CW];
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: if (nrn_valid_in) begin
        data_d  = nrn_data_in;
        idx_d   = '0;
        state_d = SEND;
      end
      SEND: if (sw_ready_in) begin
        if (idx_q == LAST_C) state_d = IDLE;
        else                 idx_d   = idx_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  assign sw_valid_out  = (state_q == SEND);
  assign nrn_ready_out = rstn & (state_q == IDLE);
  assign sw_data_out   = {data_q, MY_X, MY_Y, dest};

endmodule

// File: tb/tb_noc_pe_interface.sv
// Directed bench for noc_pe_interface with a queue-based reference
// model checked against the DUT on every falling edge.
module tb_noc_pe_interface;

  logic        clk = 0;
  logic        rstn;
  logic        sw_valid_in, sw_ready_out, sw_valid_out, sw_ready_in;
  logic [15:0] sw_data_in, sw_data_out;
  logic        nrn_valid_out, nrn_ready_in, nrn_valid_in, nrn_ready_out;
  logic [7:0]  nrn_data_out, nrn_data_in, misroute_cnt;
  logic [3:0]  nrn_src_out;

  int vecs = 0;
  int errs = 0;
  bit started = 0;

  logic [11:0] ejq[$];
  logic [15:0] injq[$];
  int          mcnt = 0;
  logic [3:0]  dests [4] = '{4'h4, 4'h5, 4'h6, 4'h7};

  always #5 clk = ~clk;

  noc_pe_interface #(
    .MY_X(2'd1), .MY_Y(2'd0), .FIFO_DEPTH(4),
    .NUM_DEST(4), .DEST_LIST(16'h7654)
  ) dut (
    .clk(clk), .rstn(rstn),
    .sw_valid_in(sw_valid_in), .sw_data_in(sw_data_in),
    .sw_ready_out(sw_ready_out), .sw_valid_out(sw_valid_out),
    .sw_data_out(sw_data_out), .sw_ready_in(sw_ready_in),
    .nrn_valid_out(nrn_valid_out), .nrn_data_out(nrn_data_out),
    .nrn_src_out(nrn_src_out), .nrn_ready_in(nrn_ready_in),
    .nrn_valid_in(nrn_valid_in), .nrn_data_in(nrn_data_in),
    .nrn_ready_out(nrn_ready_out), .misroute_cnt(misroute_cnt)
  );

  function automatic logic [15:0] mk(
    input logic [7:0] d, input logic [1:0] sx, sy, dx, dy);
    return {d, sx, sy, dx, dy};
  endfunction

  task automatic chk(input string n,
                     input logic [31:0] a, input logic [31:0] e);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask

  always @(posedge clk) begin
    if (!rstn) begin
      ejq.delete();
      injq.delete();
      mcnt = 0;
    end else begin
      bit room, busy;
      room = ejq.size() < 4;
      busy = injq.size() > 0;
      if (ejq.size() > 0 && nrn_ready_in) void'(ejq.pop_front());
      if (sw_valid_in && room) begin
        if (sw_data_in[3:0] == 4'b0100)
          ejq.push_back({sw_data_in[15:8], sw_data_in[7:4]});
        else if (mcnt < 255)
          mcnt++;
      end
      if (busy && sw_ready_in) void'(injq.pop_front());
      else if (!busy && nrn_valid_in)
        for (int k = 0; k < 4; k++)
          injq.push_back({nrn_data_in, 4'b0100, dests[k]});
    end
  end

  always @(negedge clk) if (started) begin
    chk("sw_ready", sw_ready_out, rstn && ejq.size() < 4);
    chk("nrn_valid", nrn_valid_out, ejq.size() > 0);
    if (ejq.size() > 0)
      chk("nrn_payload", {nrn_data_out, nrn_src_out}, ejq[0]);
    chk("misroute", misroute_cnt, mcnt);
    chk("sw_valid", sw_valid_out, injq.size() > 0);
    if (injq.size() > 0) chk("sw_data", sw_data_out, injq[0]);
    chk("nrn_ready", nrn_ready_out, rstn && injq.size() == 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_flit(input int k, input logic [7:0] d);
    logic [1:0] y;
    y = 2'(k);
    chk("flit_valid", sw_valid_out, 1);
    chk("flit_data", sw_data_out, mk(d, 2'd1, 2'd0, 2'd1, y));
  endtask

  initial begin
    bit ok;
    rstn = 0; sw_valid_in = 0; sw_data_in = '0; sw_ready_in = 0;
    nrn_ready_in = 0; nrn_valid_in = 0; nrn_data_in = '0;
    repeat (3) tick();
    started = 1;
    chk("rst_sw_ready", sw_ready_out, 0);
    chk("rst_nrn_valid", nrn_valid_out, 0);
    rstn = 1;
    tick();

    // T1
    sw_valid_in = 1; sw_data_in = mk(8'h5A, 0, 0, 1, 0);
    nrn_ready_in = 1;
    tick();
    sw_valid_in = 0;
    chk("t1_valid", nrn_valid_out, 1);
    chk("t1_data", nrn_data_out, 8'h5A);
    chk("t1_src", nrn_src_out, 4'b0000);
    tick();

    // T2
    nrn_ready_in = 0;
    for (int i = 1; i <= 4; i++) begin
      sw_valid_in = 1; sw_data_in = mk(8'(i), 2, 1, 1, 0);
      tick();
    end
    chk("t2_full", sw_ready_out, 0);
    sw_data_in = mk(8'd5, 2, 1, 1, 0);
    repeat (2) tick();
    chk("t2_hold", sw_ready_out, 0);
    chk("t2_head", nrn_data_out, 8'd1);
    nrn_ready_in = 1;
    ok = 0;
    for (int b = 0; b < 20 && !ok; b++) begin
      ok = sw_ready_out;
      tick();
    end
    chk("t2_accept5", ok, 1);
    sw_valid_in = 0;
    repeat (6) tick();

    // T3
    sw_valid_in = 1; sw_data_in = mk(8'hAA, 0, 0, 2, 3);
    tick();
    sw_valid_in = 0;
    chk("t3_cnt1", misroute_cnt, 8'd1);
    chk("t3_novalid", nrn_valid_out, 0);
    sw_valid_in = 1;
    repeat (299) tick();
    sw_valid_in = 0;
    chk("t3_sat", misroute_cnt, 8'd255);

    // T4
    sw_ready_in = 1; nrn_valid_in = 1; nrn_data_in = 8'hC3;
    tick();
    nrn_valid_in = 0;
    for (int k = 0; k < 4; k++) begin
      check_flit(k, 8'hC3);
      tick();
    end
    chk("t4_idle", sw_valid_out, 0);
    chk("t4_ready", nrn_ready_out, 1);

    // T5
    nrn_valid_in = 1; nrn_data_in = 8'h3C;
    tick();
    nrn_valid_in = 0;
    check_flit(0, 8'h3C);
    tick();
    sw_ready_in = 0;
    repeat (3) begin
      check_flit(1, 8'h3C);
      tick();
    end
    sw_ready_in = 1;
    for (int k = 1; k < 4; k++) begin
      check_flit(k, 8'h3C);
      tick();
    end
    chk("t5_idle", sw_valid_out, 0);

    // T6
    nrn_ready_in = 0;
    sw_valid_in = 1; sw_data_in = mk(8'hE1, 3, 3, 1, 0);
    tick();
    sw_data_in = mk(8'hE2, 3, 3, 1, 0);
    tick();
    sw_valid_in = 0;
    nrn_valid_in = 1; nrn_data_in = 8'h77;
    tick();
    nrn_valid_in = 0;
    tick();
    check_flit(1, 8'h77);
    rstn = 0;
    tick();
    chk("t6_swv", sw_valid_out, 0);
    chk("t6_nrnv", nrn_valid_out, 0);
    chk("t6_swr", sw_ready_out, 0);
    chk("t6_nrnr", nrn_ready_out, 0);
    chk("t6_mis", misroute_cnt, 0);
    rstn = 1;
    nrn_valid_in = 1; nrn_data_in = 8'h99;
    tick();
    nrn_valid_in = 0;
    check_flit(0, 8'h99);
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
